// File: rtl/ps2_ascii_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines, deframes scan codes and
// maps set-2 make codes to ASCII for a PicoBlaze interrupt. Define PS2_PARITY_CHECK_EN to enforce odd parity.
module ps2_ascii_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       DoRead,
    output logic [7:0] ascii_code,
    output logic       interrupt,
    output logic       overflow,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic          c_s1, c_s2, d_s1, d_s2;
    logic          c_filt;
    logic [FW-1:0] filt_cnt;
    logic          strobe;
    logic [1:0]    state;
    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic          brk, ext;
    logic          parity_ok, frame_ok;
    logic [8:0]    mapped;

    function automatic logic [8:0] map_code(input logic [7:0] c);
        logic [7:0] a;
        a = 8'h00;
        case (c)
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        return {(a != 8'h00), a};
    endfunction

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            {c_s1, c_s2, d_s1, d_s2} <= 4'b1111;
        end else begin
            c_s1 <= ps2c;
            c_s2 <= c_s1;
            d_s1 <= ps2d;
            d_s2 <= d_s1;
        end
    end

    // Filtered clock follows the synchronized line only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            c_filt   <= 1'b1;
            filt_cnt <= '0;
        end else if (c_s2 == c_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            c_filt   <= c_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign strobe = c_filt & ~c_s2 & (filt_cnt == FILT_LAST);

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^shreg[8:0];
`else
    // Parity bit is received but deliberately not enforced
    assign parity_ok = shreg[8] | 1'b1;
`endif
    assign frame_ok = shreg[9] & parity_ok;
    assign mapped   = map_code(shreg[7:0]);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            ascii_code <= 8'h00;
            interrupt  <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            if (DoRead)
                interrupt <= 1'b0;
            case (state)
                IDLE: begin
                    if (strobe && !d_s2) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (strobe) begin
                        shreg  <= {d_s2, shreg[9:1]};
                        to_cnt <= '0;
                        if (bit_cnt == 4'd9)
                            state <= CHECK;
                        else
                            bit_cnt <= bit_cnt + 4'd1;
                    end else if (to_cnt == TO_LAST) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        shreg     <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                    end else if (shreg[7:0] == 8'hF0) begin
                        brk <= 1'b1;
                    end else if (shreg[7:0] == 8'hE0) begin
                        ext <= 1'b1;
                    end else if (brk || ext) begin
                        brk <= 1'b0;
                        ext <= 1'b0;
                    end else if (mapped[8]) begin
                        // An acknowledge in the same cycle frees the slot for the new character
                        if (interrupt && !DoRead) begin
                            overflow <= 1'b1;
                        end else begin
                            ascii_code <= mapped[7:0];
                            interrupt  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_ascii_rx.sv
// Scoreboard bench for ps2_ascii_rx: expected characters are queued as frames are sent and
// popped whenever the receiver loads a character.
module tb_ps2_ascii_rx;

    localparam int FLEN = 4;
    localparam int TO   = 2000;
    localparam int H    = 20;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ps2c, ps2d, do_read;
    logic [7:0] ascii_code;
    logic       interrupt, overflow, frame_err;

    int         n_vec = 0, n_err = 0;
    int         n_ovf = 0, n_ferr = 0, exp_ferr = 0;
    logic [7:0] sb[$];
    logic [7:0] prev_ascii = 8'h00;
    logic       prev_int = 1'b0;

    ps2_ascii_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .Reset(reset_n), .ps2c(ps2c), .ps2d(ps2d), .DoRead(do_read),
        .ascii_code(ascii_code), .interrupt(interrupt), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Any interrupt rise or change of ascii_code is a character load
    always @(negedge clk) begin
        if (reset_n) begin
            if ((interrupt && !prev_int) || (ascii_code != prev_ascii)) begin
                chk("load_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0)
                    chk("ascii_load", 32'(ascii_code), 32'(sb.pop_front()));
            end
            if (overflow)  n_ovf++;
            if (frame_err) n_ferr++;
        end
        prev_ascii = ascii_code;
        prev_int   = interrupt;
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2d = b;
        wait_neg(H);
        ps2c = 1'b0;
        wait_neg(H);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~^d ^ par_flip);
        send_bit(stop);
        ps2d = 1'b1;
        wait_neg(4 * H);
    endtask

    task automatic pulse_read();
        @(negedge clk) do_read = 1'b1;
        @(negedge clk) do_read = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; ps2c = 1'b1; ps2d = 1'b1; do_read = 1'b0;
        wait_neg(3);
        chk("rst_ascii", 32'(ascii_code), 32'h00);
        chk("rst_int",   32'(interrupt),  32'd0);
        chk("rst_ovf",   32'(overflow),   32'd0);
        chk("rst_ferr",  32'(frame_err),  32'd0);
        reset_n = 1'b1;
        wait_neg(5);

        // Short glitch that looks like a start bit, then an idle-state strobe with data high
        ps2d = 1'b0; ps2c = 1'b0;
        wait_neg(FLEN - 2);
        ps2c = 1'b1; ps2d = 1'b1;
        wait_neg(2 * H);
        send_bit(1'b1);
        wait_neg(2 * H);
        chk("idle_ferr", 32'(n_ferr), 32'(exp_ferr));

        sb.push_back(8'h61);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("int_set", 32'(interrupt), 32'd1);
        pulse_read();
        chk("int_clr", 32'(interrupt), 32'd0);
        chk("ascii_keep", 32'(ascii_code), 32'h61);
        pulse_read();
        chk("read_idle_int", 32'(interrupt), 32'd0);

        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("break_no_int", 32'(interrupt), 32'd0);
        sb.push_back(8'h31);
        send_frame(8'h16, 1'b0, 1'b1);
        chk("after_break_int", 32'(interrupt), 32'd1);
        pulse_read();

        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        chk("ext_no_int", 32'(interrupt), 32'd0);

`ifdef PS2_PARITY_CHECK_EN
        exp_ferr++;
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("par_no_int", 32'(interrupt), 32'd0);
`else
        sb.push_back(8'h61);
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("par_ignored_int", 32'(interrupt), 32'd1);
`endif
        chk("par_ferr", 32'(n_ferr), 32'(exp_ferr));
        pulse_read();

        sb.push_back(8'h61);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h32, 1'b0, 1'b1);
        chk("ovf_count", 32'(n_ovf), 32'd1);
        chk("ovf_ascii", 32'(ascii_code), 32'h61);

        // 0x5A whose load coincides with an acknowledge
        sb.push_back(8'h0D);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(logic'((8'h5A >> i) & 1));
        send_bit(~^8'h5A);
        ps2d = 1'b1;
        wait_neg(H);
        ps2c = 1'b0;
        wait_neg(FLEN + 2);
        do_read = 1'b1;
        @(negedge clk) do_read = 1'b0;
        chk("coinc_ascii", 32'(ascii_code), 32'h0D);
        chk("coinc_int",   32'(interrupt),  32'd1);
        wait_neg(H);
        ps2c = 1'b1;
        wait_neg(4 * H);
        chk("coinc_ovf", 32'(n_ovf), 32'd1);
        pulse_read();

        send_frame(8'h07, 1'b0, 1'b1);
        chk("unmapped_int", 32'(interrupt), 32'd0);
        exp_ferr++;
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("stop_ferr", 32'(n_ferr), 32'(exp_ferr));

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        exp_ferr++;
        wait_neg(TO + 20);
        chk("timeout_ferr", 32'(n_ferr), 32'(exp_ferr));
        sb.push_back(8'h20);
        send_frame(8'h29, 1'b0, 1'b1);
        chk("after_to_ascii", 32'(ascii_code), 32'h20);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_ascii", 32'(ascii_code), 32'h00);
        chk("mid_rst_int",   32'(interrupt),  32'd0);
        chk("mid_rst_ovf",   32'(overflow),   32'd0);
        chk("mid_rst_ferr",  32'(frame_err),  32'd0);
        wait_neg(4);
        reset_n = 1'b1;
        wait_neg(4);
        sb.push_back(8'h0D);
        send_frame(8'h5A, 1'b0, 1'b1);
        chk("post_rst_ascii", 32'(ascii_code), 32'h0D);
        chk("post_rst_int",   32'(interrupt),  32'd1);

        chk("final_ovf",  32'(n_ovf),     32'd1);
        chk("final_ferr", 32'(n_ferr),    32'(exp_ferr));
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
